// File: rtl/addsub_seq_ctrl_if.sv
// rtl/addsub_seq_ctrl_if.sv - request/response bundle for the chunked add/subtract unit
interface addsub_seq_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output req_valid, a, b, sub, resp_ready,
    input  req_ready, resp_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  req_valid, a, b, sub, resp_ready,
    output req_ready, resp_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - WIDTH-bit add/subtract built from one CHUNK-bit adder slice,
// one chunk per cycle, LSB chunk first, carry held between cycles
module addsub_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  addsub_seq_ctrl_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      base_d;
  logic [CHUNK-1:0] a_slice_d;
  logic [CHUNK-1:0] b_slice_d;
  logic [CHUNK:0]   add_d;
  logic             ovf_d;

  assign base_d    = 32'(idx_q) * 32'(CHUNK);
  assign a_slice_d = a_q[base_d +: CHUNK];
  assign b_slice_d = b_q[base_d +: CHUNK];
  assign add_d     = {1'b0, a_slice_d} + {1'b0, b_slice_d} + (CHUNK+1)'(carry_q);
  // b_q is already inverted for subtract, so this is the plain same-sign-in, different-sign-out rule
  assign ovf_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_d[CHUNK-1] != a_q[WIDTH-1]);

  assign bus.req_ready  = (state_q == IDLE) && rst_ni;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.busy       = (state_q == RUN);
  assign bus.sum        = sum_q;
  assign bus.cout       = cout_q;
  assign bus.overflow   = ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[base_d +: CHUNK] <= add_d[CHUNK-1:0];
          carry_q                <= add_d[CHUNK];
          if (idx_q == LAST) begin
            cout_q  <= add_d[CHUNK];
            ovf_q   <= ovf_d;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb/tb_addsub_seq_ctrl.sv - scoreboard bench for addsub_seq_ctrl
module tb_addsub_seq_ctrl;
  localparam int W = 64;
  localparam int C = 16;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_seq_ctrl_if #(.WIDTH(W)) bus ();

  addsub_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [65:0] exp_q[$];
  int          acc_q[$];
  logic        prev_rv = 1'b0;
  logic [65:0] mon_e;
  int          mon_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // {overflow, cout, sum} from wide unsigned and signed arithmetic
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [64:0]        u;
    logic               c;
    logic signed [65:0] sa, sb, sr;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      c  = u[64];
      sr = sa + sb;
    end
    return {(sr != $signed({{2{u[63]}}, u[63:0]})), c, u[63:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid && !prev_rv) begin
        if (acc_q.size() == 0) chk("spurious_resp_valid", 64'd1, 64'd0);
        else begin
          mon_a = acc_q.pop_front();
          chk("latency", 64'(cyc - mon_a), 64'(N));
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("sum", bus.sum, mon_e[63:0]);
          chk("cout", 64'(bus.cout), 64'(mon_e[64]));
          chk("overflow", 64'(bus.overflow), 64'(mon_e[65]));
        end
      end
    end
    prev_rv <= bus.resp_valid;
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(model(a, b, s));
      acc_q.push_back(cyc);
      bus.req_valid = 1'b0;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      @(posedge clk); #1;
      bus.resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      done = bus.resp_valid && bus.resp_ready;
      n++;
    end
    if (!done) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [63:0] da[8];
  logic [63:0] db[8];
  logic        ds[8];
  logic [65:0] e1;
  logic [63:0] o2a, o2b;
  int          n;

  initial begin
    bus.req_valid  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.sub        = 1'b0;
    bus.resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

    da[0] = 64'h0000_0000_FFFF_FFFF; db[0] = 64'd1; ds[0] = 1'b0;
    da[1] = 64'd5;                   db[1] = 64'd7; ds[1] = 1'b1;
    da[2] = 64'd7;                   db[2] = 64'd5; ds[2] = 1'b1;
    da[3] = 64'h7FFF_FFFF_FFFF_FFFF; db[3] = 64'd1; ds[3] = 1'b0;
    da[4] = 64'h8000_0000_0000_0000; db[4] = 64'd1; ds[4] = 1'b1;
    da[5] = 64'hFFFF_FFFF_FFFF_FFFF; db[5] = 64'd1; ds[5] = 1'b0;
    da[6] = 64'h1234_0000_0000_0000; db[6] = 64'd0; ds[6] = 1'b1;
    da[7] = 64'h0000_FFFF_0000_FFFF; db[7] = 64'h0000_0001_0000_0001; ds[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(da[i], db[i], ds[i]);
      drain(1'b0);
    end

    // backpressure with req_valid held high and operands toggling
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    e1 = model(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    send(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    bus.req_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.resp_valid) break;
      @(posedge clk); #1;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = 1'($urandom_range(0, 1));
      n++;
    end
    chk("bp_resp_valid_rise", 64'(bus.resp_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_sum", bus.sum, e1[63:0]);
      chk("bp_cout", 64'(bus.cout), 64'(e1[64]));
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    o2a = {$urandom, $urandom};
    o2b = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    bus.a = o2a;
    bus.b = o2b;
    bus.sub = 1'b0;
    @(negedge clk);
    chk("bp_no_accept_on_resp", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_req_ready_after_release", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    exp_q.push_back(model(o2a, o2b, 1'b0));
    acc_q.push_back(cyc);
    bus.req_valid = 1'b0;
    drain(1'b0);

    // abort in the second RUN cycle
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0);
    @(posedge clk); #1;
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    chk("abort_req_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("abort_sum", bus.sum, 64'd0);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    chk("abort_overflow", 64'(bus.overflow), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      send(pick(), pick(), 1'($urandom_range(0, 1)));
      drain(1'b1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Multi-cycle wide add/subtract unit that reuses one CHUNK-bit adder slice over several cycles. It processes one chunk per cycle, least-significant chunk first, with the carry held in a register.
- Uses a valid/ready request/response handshake, so a narrow adder can serve WIDTH-bit operations in the datapath.
- Subtract is formed as a + ~b + 1: b is XORed with sub, and the carry-in is seeded with sub.

Parameters:
- WIDTH, 64, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, adder slice width; must be >= 2.
- N (derived, not overridable), WIDTH/CHUNK, number of chunk cycles.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- req_valid, input, 1, request valid.
- req_ready, output, 1, unit can accept a request.
- a, input, WIDTH, operand A; sampled on request handshake only.
- b, input, WIDTH, operand B; sampled on request handshake only.
- sub, input, 1, 1 = a - b, 0 = a + b; sampled on request handshake.
- resp_valid, output, 1, result valid.
- resp_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, result modulo 2^WIDTH.
- cout, output, 1, final carry out; for subtract, 1 = no borrow.
- overflow, output, 1, signed two's-complement overflow.
- busy, output, 1, operation in progress (state RUN).

Behaviour:
- Reset: clk and rst_n as above; reset is synchronous, active-low.
  - rst_n low at a rising edge: state <= IDLE, chunk index <= 0, carry <= 0, sum <= 0, cout <= 0, overflow <= 0.
  - While rst_n is low, req_ready = 0, resp_valid = 0, busy = 0, and requests are ignored.
- req_ready = (state == IDLE) && rst_n; resp_valid = (state == DONE); busy = (state == RUN).
- IDLE:
  - On req_valid && req_ready: latch a_r = a and b_r = b ^ {WIDTH{sub}}; carry <= sub; idx <= 0; state <= RUN.
  - Otherwise stay in IDLE.
  - sum, cout and overflow keep their previous values (last result).
- RUN, each cycle:
  - {c, s} = a_r[idx*CHUNK +: CHUNK] + b_r[idx*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - sum[idx*CHUNK +: CHUNK] <= s; carry <= c; idx <= idx + 1.
  - When idx == N-1: cout <= c; overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]); state <= DONE; idx <= 0.
  - Requests are not accepted (req_ready = 0).
- DONE:
  - resp_valid = 1; sum, cout and overflow are stable and complete.
  - On resp_ready: state <= IDLE, so req_ready = 1 in the following cycle.
  - Without resp_ready: hold indefinitely; outputs do not change.
  - There is no accept in the same cycle as the response handshake.
- Latency and throughput:
  - Handshake accepted in cycle 0 gives resp_valid high from cycle N through the response handshake cycle.
  - With resp_ready tied high, the peak rate is one operation per N+2 cycles.
- Ordering and width rules:
  - sum chunks are written in ascending order; the full sum is valid only when resp_valid = 1.
  - No intermediate value is guaranteed during RUN.
  - All arithmetic is unsigned modulo; overflow is the only signed interpretation.
- Boundary conditions:
  - req_valid held high while the unit is busy has no effect and must not be dropped by the source.
  - Operand inputs changing after acceptance have no effect on the result.
  - rst_n low during RUN or DONE aborts the operation: no response is issued and outputs are cleared.
  - N == 1 (WIDTH == CHUNK): RUN lasts exactly one cycle.

Test Plan:
- Add across a chunk boundary: a = 0x00000000FFFFFFFF, b = 1, sub = 0, resp_ready = 1 -> resp_valid in cycle 4 after accept; sum = 0x0000000100000000, cout = 0, overflow = 0.
- Subtract with borrow: a = 5, b = 7, sub = 1 -> sum = 0xFFFFFFFFFFFFFFFE, cout = 0, overflow = 0. Also a = 7, b = 5, sub = 1 -> sum = 2, cout = 1.
- Signed overflow: a = 0x7FFFFFFFFFFFFFFF, b = 1, sub = 0 -> sum = 0x8000000000000000, overflow = 1, cout = 0. Also a = 0x8000000000000000, b = 1, sub = 1 -> sum = 0x7FFFFFFFFFFFFFFF, overflow = 1, cout = 1.
- Full carry ripple: a = 0xFFFFFFFFFFFFFFFF, b = 1, sub = 0 -> sum = 0, cout = 1, overflow = 0.
- Backpressure:
  - Setup: resp_ready = 0 for 3 cycles after resp_valid rises, with req_valid held high and operands toggling.
  - Required: resp_valid, sum and cout stay stable; req_ready = 0.
  - Release: on resp_ready = 1, req_ready = 1 in the next cycle and the next request is accepted then.
- Reset mid-operation: rst_n low for 1 cycle during the 2nd RUN cycle -> next cycle busy = 0, resp_valid = 0, sum = 0, req_ready = 1 after rst_n returns high; no response is ever issued for the aborted request.
